// File: rtl/lane_deserializer.sv
// Packs NUM_LANES consecutive WIDTH-bit samples into one word for the adder trees.
// Define LANE_DESERIALIZER_SKID_EN to add a separate output register (no bubble).
module lane_deserializer #(
    parameter int WIDTH     = 16,
    parameter int NUM_LANES = 5
) (
    input  logic                           i_clock,
    input  logic                           i_reset,
    input  logic                           i_enable,
    input  logic [WIDTH-1:0]               i_data,
    input  logic                           i_valid,
    input  logic                           i_last,
    output logic                           o_ready,
    output logic [NUM_LANES*WIDTH-1:0]     o_lanes,
    output logic [$clog2(NUM_LANES+1)-1:0] o_count,
    output logic                           o_valid,
    input  logic                           i_ready
);

    localparam int LW  = NUM_LANES * WIDTH;
    localparam int CW  = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int CNW = $clog2(NUM_LANES + 1);
    localparam logic [CW-1:0] LAST = CW'(NUM_LANES - 1);

    logic [LW-1:0] acc;
    logic [LW-1:0] word;
    logic [CW-1:0] cnt;
    logic          at_end;
    logic          accept;
    logic          complete;

    assign at_end   = (cnt == LAST);
    assign accept   = i_valid & o_ready;
    assign complete = accept & (at_end | i_last);

    // Accumulator with the incoming sample dropped into lane[cnt]
    always_comb begin
        word = acc;
        word[cnt*WIDTH +: WIDTH] = i_data;
    end

`ifdef LANE_DESERIALIZER_SKID_EN
    logic [LW-1:0] out;
    logic          stall;

    // Only a completing beat can overwrite a word still held downstream
    assign stall   = o_valid & ~i_ready & (at_end | (i_valid & i_last));
    assign o_ready = i_enable & ~i_reset & ~stall;
    assign o_lanes = out;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            acc     <= '0;
            out     <= '0;
            cnt     <= '0;
            o_valid <= 1'b0;
            o_count <= '0;
        end else if (i_enable) begin
            if (accept) begin
                acc <= complete ? '0 : word;
                cnt <= complete ? '0 : cnt + CW'(1);
            end
            if (complete) begin
                out     <= word;
                o_valid <= 1'b1;
                o_count <= CNW'(cnt) + CNW'(1);
            end else if (o_valid & i_ready) begin
                o_valid <= 1'b0;
            end
        end
    end
`else
    // Accumulator doubles as the output word; it is cleared once consumed
    assign o_ready = i_enable & ~i_reset & ~o_valid;
    assign o_lanes = acc;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            acc     <= '0;
            cnt     <= '0;
            o_valid <= 1'b0;
            o_count <= '0;
        end else if (i_enable) begin
            if (complete) begin
                acc     <= word;
                cnt     <= '0;
                o_valid <= 1'b1;
                o_count <= CNW'(cnt) + CNW'(1);
            end else if (accept) begin
                acc <= word;
                cnt <= cnt + CW'(1);
            end else if (o_valid & i_ready) begin
                acc     <= '0;
                o_valid <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_lane_deserializer.sv
// Directed bench for lane_deserializer (WIDTH=16, NUM_LANES=5), both builds.
// Word vectors come from a table; multi-cycle corners are hand-written sequences.
module tb_lane_deserializer;

`ifdef LANE_DESERIALIZER_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        i_reset;
    logic        i_enable;
    logic [15:0] i_data;
    logic        i_valid;
    logic        i_last;
    logic        o_ready;
    logic [79:0] o_lanes;
    logic [2:0]  o_count;
    logic        o_valid;
    logic        i_ready;

    int checks   = 0;
    int failures = 0;

    logic [82:0] q[$];

    lane_deserializer #(.WIDTH(16), .NUM_LANES(5)) dut (
        .i_clock (clk),
        .i_reset (i_reset),
        .i_enable(i_enable),
        .i_data  (i_data),
        .i_valid (i_valid),
        .i_last  (i_last),
        .o_ready (o_ready),
        .o_lanes (o_lanes),
        .o_count (o_count),
        .o_valid (o_valid),
        .i_ready (i_ready)
    );

    always #5 clk = ~clk;

    // Record every downstream transfer
    always @(posedge clk)
        if (!i_reset && i_enable && o_valid && i_ready)
            q.push_back({o_count, o_lanes});

    typedef struct {
        int               n;
        logic             lastf;
        logic [4:0][15:0] d;
        logic [79:0]      lanes;
        logic [2:0]       cnt;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string nm, input logic [79:0] act,
                       input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, act, exp);
        end
    endtask

    // Enters and returns at a negedge; the sample is taken on the edge between
    task automatic send(input logic [15:0] d, input logic l);
        int n;
        n = 0;
        i_valid = 1'b1;
        i_data  = d;
        i_last  = l;
        #1;
        while (!o_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 50) begin
            checks++;
            failures++;
            $display("FAIL send_timeout data=%h", d);
        end
        @(negedge clk);
        i_valid = 1'b0;
        i_last  = 1'b0;
    endtask

    task automatic wait_q(input int need);
        int n;
        n = 0;
        while (q.size() < need && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (q.size() < need) begin
            failures++;
            $display("FAIL wait_words got=%0d need=%0d", q.size(), need);
        end
    endtask

    task automatic check_word(input string nm, input logic [79:0] lanes,
                              input logic [2:0] cnt);
        logic [82:0] w;
        if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s no_word got=0 exp=1", nm);
            return;
        end
        w = q.pop_front();
        chk({nm, "_lanes"}, w[79:0], lanes);
        chk({nm, "_count"}, {77'b0, w[82:80]}, {77'b0, cnt});
    endtask

    task automatic do_reset();
        @(negedge clk);
        i_reset = 1'b1;
        #1;
        chk("reset_ready", {79'b0, o_ready}, 80'd0);
        @(negedge clk);
        i_reset = 1'b0;
    endtask

    function automatic vec_t mk(int n, logic lf, logic [4:0][15:0] d,
                                logic [79:0] lanes, logic [2:0] cnt);
        vec_t v;
        v.n     = n;
        v.lastf = lf;
        v.d     = d;
        v.lanes = lanes;
        v.cnt   = cnt;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nxt;
        int acc_n;
        int bub;
        int cyc;

        tbl[0] = mk(5, 1'b0, {16'd5, 16'd4, 16'd3, 16'd2, 16'd1},
                    {16'd5, 16'd4, 16'd3, 16'd2, 16'd1}, 3'd5);
        tbl[1] = mk(2, 1'b1, {16'd0, 16'd0, 16'd0, 16'd20, 16'd10},
                    {16'd0, 16'd0, 16'd0, 16'd20, 16'd10}, 3'd2);
        tbl[2] = mk(5, 1'b0, {16'd2, 16'd1, 16'd9, 16'd8, 16'd7},
                    {16'd2, 16'd1, 16'd9, 16'd8, 16'd7}, 3'd5);
        tbl[3] = mk(1, 1'b1, {16'd0, 16'd0, 16'd0, 16'd0, 16'hAAAA},
                    {16'd0, 16'd0, 16'd0, 16'd0, 16'hAAAA}, 3'd1);
        tbl[4] = mk(5, 1'b1, {16'd15, 16'd14, 16'd13, 16'd12, 16'd11},
                    {16'd15, 16'd14, 16'd13, 16'd12, 16'd11}, 3'd5);
        tbl[5] = mk(4, 1'b1, {16'd0, 16'h0000, 16'h8000, 16'h0001, 16'hFFFF},
                    {16'd0, 16'h0000, 16'h8000, 16'h0001, 16'hFFFF}, 3'd4);
        tbl[6] = mk(3, 1'b1, {16'd0, 16'd0, 16'h000C, 16'h0000, 16'h0003},
                    {16'd0, 16'd0, 16'h000C, 16'h0000, 16'h0003}, 3'd3);

        i_reset  = 1'b1;
        i_enable = 1'b1;
        i_data   = '0;
        i_valid  = 1'b0;
        i_last   = 1'b0;
        i_ready  = 1'b1;

        // Reset state
        @(negedge clk);
        #1;
        chk("reset_ready", {79'b0, o_ready}, 80'd0);
        @(negedge clk);
        i_reset = 1'b0;
        #1;
        chk("rst_valid", {79'b0, o_valid}, 80'd0);
        chk("rst_lanes", o_lanes, 80'd0);
        chk("rst_count", {77'b0, o_count}, 80'd0);
        chk("rst_ready_after", {79'b0, o_ready}, 80'd1);
        @(negedge clk);

        // Latency and single-cycle o_valid
        for (int k = 1; k <= 5; k++) send(16'(k), 1'b0);
        #1;
        chk("lat_valid", {79'b0, o_valid}, 80'd1);
        chk("lat_count", {77'b0, o_count}, 80'd5);
        chk("lat_lanes", o_lanes, {16'd5, 16'd4, 16'd3, 16'd2, 16'd1});
        @(negedge clk);
        #1;
        chk("lat_pulse", {79'b0, o_valid}, 80'd0);
        @(negedge clk);
        q.delete();

        // Backpressure: word held while downstream stalls
        i_ready = 1'b0;
        for (int k = 11; k <= 15; k++) send(16'(k), 1'b0);
        nxt = 21;
        for (int k = 0; k < 5; k++) begin
            i_valid = 1'b1;
            i_data  = 16'(nxt);
            #1;
            chk("bp_valid", {79'b0, o_valid}, 80'd1);
            chk("bp_count", {77'b0, o_count}, 80'd5);
            chk("bp_lanes", o_lanes, {16'd15, 16'd14, 16'd13, 16'd12, 16'd11});
            chk("bp_ready", {79'b0, o_ready}, {79'b0, (SKID && k < 4)});
            if (o_ready) nxt++;
            @(negedge clk);
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        for (int d = nxt; d <= 25; d++) send(16'(d), 1'b0);
        wait_q(2);
        check_word("bp_w0", {16'd15, 16'd14, 16'd13, 16'd12, 16'd11}, 3'd5);
        check_word("bp_w1", {16'd25, 16'd24, 16'd23, 16'd22, 16'd21}, 3'd5);
        @(negedge clk);

        // Continuous stream of 20 samples
        acc_n = 0;
        bub   = 0;
        cyc   = 0;
        while (acc_n < 20 && cyc < 60) begin
            i_valid = 1'b1;
            i_data  = 16'(acc_n + 1);
            #1;
            if (o_ready) acc_n++;
            else bub++;
            cyc++;
            @(negedge clk);
        end
        i_valid = 1'b0;
        chk("stream_accepted", 80'(acc_n), 80'd20);
        chk("stream_bubbles", 80'(bub), SKID ? 80'd0 : 80'd3);
        wait_q(4);
        for (int j = 0; j < 4; j++)
            check_word("stream_w",
                       {16'(5*j+5), 16'(5*j+4), 16'(5*j+3), 16'(5*j+2), 16'(5*j+1)},
                       3'd5);
        @(negedge clk);

        // Reset mid-word discards the partial
        send(16'd101, 1'b0);
        send(16'd102, 1'b0);
        send(16'd103, 1'b0);
        do_reset();
        for (int d = 201; d <= 206; d++) send(16'(d), 1'b0);
        wait_q(1);
        check_word("rst_mid", {16'd205, 16'd204, 16'd203, 16'd202, 16'd201}, 3'd5);
        repeat (3) @(negedge clk);
        chk("rst_mid_extra", 80'(q.size()), 80'd0);

        // Enable freeze
        do_reset();
        send(16'd31, 1'b0);
        send(16'd32, 1'b0);
        i_enable = 1'b0;
        i_valid  = 1'b1;
        i_data   = 16'd33;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("frz_ready", {79'b0, o_ready}, 80'd0);
            @(negedge clk);
        end
        i_enable = 1'b1;
        send(16'd33, 1'b0);
        send(16'd34, 1'b0);
        i_ready = 1'b0;
        send(16'd35, 1'b0);
        i_enable = 1'b0;
        i_ready  = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("frz_hold_valid", {79'b0, o_valid}, 80'd1);
            chk("frz_hold_lanes", o_lanes, {16'd35, 16'd34, 16'd33, 16'd32, 16'd31});
            @(negedge clk);
        end
        chk("frz_no_xfer", 80'(q.size()), 80'd0);
        i_enable = 1'b1;
        wait_q(1);
        check_word("frz_word", {16'd35, 16'd34, 16'd33, 16'd32, 16'd31}, 3'd5);
        @(negedge clk);

        // Table of word vectors
        for (int i = 0; i < 7; i++) begin
            for (int j = 0; j < tbl[i].n; j++)
                send(tbl[i].d[j], tbl[i].lastf && (j == tbl[i].n - 1));
            wait_q(1);
            check_word("tbl", tbl[i].lanes, tbl[i].cnt);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
